dmem_arbiter: RTL and testbench

- Shares the single-port data memory between the pipeline MEM stage (CPU port) and an external loader/DMA port (EXT port).
- The CPU has fixed priority. A starvation counter forces an EXT grant after MAX_WAIT denied cycles, stalling the pipeline for that one cycle.
- Sits between the MEM stage / hazard logic and the dmem instance.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_arb_starve_cnt.sv | 30 +++
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

    localparam int ARB_CNT_W  = 4;
    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CPU,
        S_EXT
    } arb_state_e;

    // One memory access as presented by a requester or by the mux; sized by
    // the package widths, so the top's width parameters must match them.
    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// rtl/dmem_arb_starve_cnt.sv - saturating EXT wait counter that raises the forced-grant flag
module dmem_arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 ext_req,
    input  logic                 ext_gnt,
    output logic [ARB_CNT_W-1:0] wait_cnt,
    output logic                 force_ext
);

    localparam logic [ARB_CNT_W-1:0] MAX_CNT = ARB_CNT_W'(MAX_WAIT);

    assign force_ext = ext_req & (wait_cnt == MAX_CNT);

    // A dropped request starts the count over, so only consecutive denials count.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wait_cnt <= '0;
        end else if (!ext_req || ext_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != MAX_CNT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority dmem arbiter with EXT anti-starvation; optional DMEM_ARB_STATS_EN counters
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH = MEM_ADDR_W,
    parameter int DATA_WIDTH      = MEM_DATA_W,
    parameter int MAX_WAIT        = 4
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic                       cpu_req,
    input  logic                       cpu_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]      cpu_wdata,
    output logic [DATA_WIDTH-1:0]      cpu_rdata,
    output logic                       cpu_stall,
    input  logic                       ext_req,
    input  logic                       ext_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0]      ext_wdata,
    output logic                       ext_gnt,
    output logic                       ext_rvalid,
    output logic [DATA_WIDTH-1:0]      ext_rdata,
    output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_din,
    output logic                       mem_read,
    output logic                       mem_write,
    input  logic [DATA_WIDTH-1:0]      mem_dout
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]                stat_stall_cnt,
    output logic [15:0]                stat_ext_cnt
`endif
);

    arb_state_e           state;
    arb_state_e           state_nxt;
    mem_req_t             cpu_r;
    mem_req_t             ext_r;
    mem_req_t             mux;
    logic                 force_ext;
    logic                 cpu_grant;
    logic                 ext_grant;
    logic                 ext_rd_q;
    logic [ARB_CNT_W-1:0] wait_cnt;

    assign cpu_r = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    assign ext_r = '{we: ext_we, addr: ext_addr, wdata: ext_wdata};

    dmem_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk       (clk),
        .reset_b   (reset_b),
        .ext_req   (ext_req),
        .ext_gnt   (ext_grant),
        .wait_cnt  (wait_cnt),
        .force_ext (force_ext)
    );

    // The two grants are mutually exclusive: EXT only wins when the CPU is idle or forced out.
    always_comb begin
        ext_grant = ext_req & (~cpu_req | force_ext);
        cpu_grant = cpu_req & ~force_ext;
        mux       = cpu_r;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        state_nxt = S_IDLE;
        if (ext_grant) begin
            mux       = ext_r;
            state_nxt = S_EXT;
        end else if (cpu_grant) begin
            state_nxt = S_CPU;
        end
        if (ext_grant || cpu_grant) begin
            mem_read  = ~mux.we;
            mem_write = mux.we;
        end
    end

    assign mem_addr   = mux.addr;
    assign mem_din    = mux.wdata;
    assign cpu_rdata  = mem_dout;
    assign cpu_stall  = cpu_req & force_ext;
    assign ext_gnt    = ext_grant;
    assign ext_rvalid = (state == S_EXT) & ext_rd_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state    <= S_IDLE;
            ext_rd_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            ext_rd_q <= ext_grant & ~ext_we;
        end
    end

    // Read data is captured only on EXT read grants and otherwise held.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ext_rdata <= '0;
        end else if (ext_grant && !ext_we) begin
            ext_rdata <= mem_dout;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            stat_stall_cnt <= '0;
            stat_ext_cnt   <= '0;
        end else begin
            if (cpu_stall && (stat_stall_cnt != 16'hFFFF)) begin
                stat_stall_cnt <= stat_stall_cnt + 16'd1;
            end
            if (ext_grant && (stat_ext_cnt != 16'hFFFF)) begin
                stat_ext_cnt <= stat_ext_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk;
    logic        reset_b;
    logic        cpu_req;
    logic        cpu_we;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        ext_req;
    logic        ext_we;
    logic [9:0]  ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_gnt;
    logic        ext_rvalid;
    logic [31:0] ext_rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_dout;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_stall_cnt;
    logic [15:0] stat_ext_cnt;
`endif

    logic        bd_we;
    logic [9:0]  bd_addr;
    logic [31:0] bd_data;
    logic [31:0] mem [0:1023];

    int total = 0;
    int bad   = 0;

    dmem_arbiter dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_dout   (mem_dout)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_stall_cnt (stat_stall_cnt),
        .stat_ext_cnt   (stat_ext_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dmem model: combinational read, write at the clock edge; bd_* preloads it
    assign mem_dout = mem[mem_addr];
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_din;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        step();
        bd_we   = 1'b0;
    endtask

    initial begin
        reset_b   = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        ext_req   = 1'b0;
        ext_we    = 1'b0;
        ext_addr  = '0;
        ext_wdata = '0;
        bd_we     = 1'b0;
        bd_addr   = '0;
        bd_data   = '0;
        preload(10'd0, 32'h0);
        preload(10'd3, 32'h0);
        preload(10'd5, 32'hDEADBEEF);
        preload(10'd7, 32'hA5A5A5A5);

        #1;
        chk("rst_rvalid", ext_rvalid, 0);
        chk("rst_rdata", ext_rdata, 0);
        chk("rst_gnt", ext_gnt, 0);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_mrd", mem_read, 0);
        chk("rst_mwr", mem_write, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        reset_b = 1'b1;

        // CPU load, same-cycle data
        cpu_req  = 1'b1;
        cpu_addr = 10'd5;
        #1;
        chk("cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("cpu_stall", cpu_stall, 0);
        chk("cpu_mrd", mem_read, 1);
        chk("cpu_maddr", mem_addr, 5);
        step();

        // EXT write then read back
        cpu_req   = 1'b0;
        ext_req   = 1'b1;
        ext_we    = 1'b1;
        ext_addr  = 10'd3;
        ext_wdata = 32'h1234;
        #1;
        chk("extw_gnt", ext_gnt, 1);
        chk("extw_mwr", mem_write, 1);
        chk("extw_maddr", mem_addr, 3);
        chk("extw_mdin", mem_din, 32'h1234);
        step();
        ext_we = 1'b0;
        #1;
        chk("extr_gnt", ext_gnt, 1);
        chk("extr_mrd", mem_read, 1);
        chk("extr_rvalid_after_wr", ext_rvalid, 0);
        step();
        ext_req = 1'b0;
        #1;
        chk("extr_rvalid", ext_rvalid, 1);
        chk("extr_rdata", ext_rdata, 32'h1234);
        step();
        #1;
        chk("extr_rvalid_drop", ext_rvalid, 0);
        chk("extr_rdata_hold", ext_rdata, 32'h1234);

        // Sustained contention: forced EXT grant every fifth cycle
        cpu_req  = 1'b1;
        cpu_addr = 10'd5;
        ext_req  = 1'b1;
        ext_we   = 1'b0;
        ext_addr = 10'd7;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("cont_gnt%0d", i), ext_gnt, (i % 5 == 4) ? 1 : 0);
            chk($sformatf("cont_stall%0d", i), cpu_stall, (i % 5 == 4) ? 1 : 0);
            chk($sformatf("cont_maddr%0d", i), mem_addr, (i % 5 == 4) ? 7 : 5);
            chk($sformatf("cont_rvalid%0d", i), ext_rvalid, (i == 5) ? 1 : 0);
            step();
        end
        chk("cont_rdata", ext_rdata, 32'hA5A5A5A5);

        // Short EXT pulse, drop, re-raise: count restarts
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("pulse_gnt%0d", i), ext_gnt, 0);
            step();
        end
        ext_req = 1'b0;
        step();
        ext_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("rerise_gnt%0d", i), ext_gnt, (i == 4) ? 1 : 0);
            step();
        end

        // Async reset with a pending read response
        cpu_req = 1'b0;
        step();
        #1;
        chk("rst1_rvalid_pre", ext_rvalid, 1);
        reset_b = 1'b0;
        #1;
        chk("rst1_rvalid", ext_rvalid, 0);
        chk("rst1_rdata", ext_rdata, 0);
        step();
        reset_b = 1'b1;

        // Async reset while EXT write is being denied
        cpu_req   = 1'b1;
        ext_we    = 1'b1;
        ext_addr  = 10'd3;
        ext_wdata = 32'hBAD0BAD0;
        step();
        step();
        step();
        #1;
        chk("rst2_wcnt_pre", dut.u_starve.wait_cnt, 3);
        chk("rst2_mwr_pre", mem_write, 0);
        reset_b = 1'b0;
        #1;
        chk("rst2_wcnt", dut.u_starve.wait_cnt, 0);
        chk("rst2_mwr", mem_write, 0);
        step();
        cpu_req = 1'b0;
        ext_req = 1'b0;
        reset_b = 1'b1;
        step();
        #1;
        chk("rst2_mem3", mem[3], 32'h1234);

`ifdef DMEM_ARB_STATS_EN
        reset_b  = 1'b0;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        ext_req  = 1'b1;
        ext_we   = 1'b0;
        ext_addr = 10'd7;
        step();
        reset_b = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
        end
        #1;
        chk("stat_stall", stat_stall_cnt, 10);
        chk("stat_ext", stat_ext_cnt, 10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
